minicpu_useq: RTL and testbench
===============================

// Module: minicpu_useq
// PURPOSE
//  Parametrised microprogram sequencer for the MiniCPU execution unit. Each cycle it
//  forms the next microaddress from the current microword's next-address fields.
//  Supports sequential, jump, conditional, multiway, call/return (hardware stack)
//  and opcode dispatch with an interrupt hook. Sits between the microcode ROM and
//  the IR/condition-code logic; its MA output addresses the ROM.
// PARAMETERS
//  IR_W      5      opcode width; dispatch table holds 2**IR_W entries
//  UA_W      8      microaddress width (UA_W > IR_W)
//  NCC       4      number of condition-code inputs (power of 2, >= 4)
//  STK_DEPTH 4      microsubroutine return stack depth (>= 1)
//  RST_VEC   'h00   microaddress loaded on reset
//  INT_VEC   'h04   microaddress taken by DSP when Int is pending
//  DSP_BASE  'h1    upper UA_W-IR_W bits of the dispatch table address
// PORTS
//  Clk    in   1                 clock; all state changes on rising edge
//  Rst    in   1                 reset; asynchronous, active-low
//  Rdy    in   1                 advance enable; 0 = hold all state
//  Int    in   1                 interrupt request (level)
//  CC     in   NCC               condition codes
//  IR     in   IR_W              instruction register opcode
//  NAOp   in   3                 next-address op from microword
//  CCSel  in   clog2(NCC)        selects CC bit for BRT
//  CCInv  in   1                 inverts selected CC for BRT
//  BA     in   UA_W              branch address field of microword
//  MA     out  UA_W              current microaddress (registered)
//  Done   out  1                 one-cycle pulse: instruction completed (registered)
//  Ack    out  1                 one-cycle pulse: interrupt accepted (registered)
//  StkErr out  1                 sticky stack overflow/underflow flag
//  SP     out  clog2(STK_DEPTH+1) stack occupancy, 0..STK_DEPTH
// BEHAVIOUR
//  Reset (Rst=0, async): MA=RST_VEC, SP=0, Done=0, Ack=0, StkErr=0, stack cleared.
//  Rdy=0: MA, SP, stack and StkErr hold; Done/Ack drive 0 that cycle.
//  With Rdy=1, on each Clk edge MA <= next(NAOp); N = MA+1 mod 2**UA_W:
//   0 NXT : N
//   1 JMP : BA
//   2 BRT : (CC[CCSel]^CCInv) ? BA : N
//   3 CALL: push N, go to BA; if SP==STK_DEPTH, no push, still go to BA, StkErr<=1
//   4 RTS : pop to top of stack; if SP==0, go to N, StkErr<=1
//   5 DSP : Int ? INT_VEC : {DSP_BASE, IR}; Done<=1 next cycle;
//           Ack<=1 next cycle iff Int; SP and stack unchanged
//   6 MWB : {BA[UA_W-1:2], CC[1:0]} (4-way branch)
//   7 HLT : MA holds; leave only by reset
//  Done/Ack are one-cycle pulses; each returns to 0 on the next edge unless a new
//   DSP executes. The Int source drops Int on seeing Ack; Int still high at the
//   next DSP is treated as a new request.
//  StkErr is cleared only by reset. The stack is LIFO, with no wrap and no overwrite.
//  MA+1 wraps from 2**UA_W-1 to 0 without error.
//  Int is sampled only on DSP with Rdy=1. Int during any other op has no effect.
//  Reset mid-operation: all state is lost immediately. There is no resumption.
// TESTING
//  1 Release reset, NAOp=NXT, Rdy=1 for 3 cycles -> MA=00,01,02,03; Done=Ack=0.
//  2 MA=10, NAOp=DSP, IR=5'h0B, Int=0 -> MA=8'h2B; Done=1 for one cycle; Ack=0.
//  3 NAOp=DSP, Int=1 -> MA=8'h04, Done=1 and Ack=1 for one cycle; IR ignored.
//  4 CALL BA=40 at MA=20, then RTS at 40 -> MA=40, SP=1, then MA=21, SP=0.
//  5 Five CALLs with STK_DEPTH=4 -> SP stops at 4, StkErr=1; RTS with SP=0 -> MA+1.
//  6 BRT CCSel=2: CC=4'b0100 with CCInv=0, then CCInv=1 -> BA taken, then N.
//    Rdy=0 on a CALL -> no change to MA or SP.

Source files
------------

// File: rtl/minicpu_useq.sv
// minicpu_useq: microprogram sequencer forming the next microaddress from the microword's next-address fields
module minicpu_useq #(
  parameter int IR_W = 5,
  parameter int UA_W = 8,
  parameter int NCC = 4,
  parameter int STK_DEPTH = 4,
  parameter logic [UA_W-1:0] RST_VEC = 'h00,
  parameter logic [UA_W-1:0] INT_VEC = 'h04,
  parameter logic [UA_W-IR_W-1:0] DSP_BASE = 'h1,
  localparam int CS_W = $clog2(NCC),
  localparam int SP_W = $clog2(STK_DEPTH + 1)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Rdy,
  input  logic            Int,
  input  logic [NCC-1:0]  CC,
  input  logic [IR_W-1:0] IR,
  input  logic [2:0]      NAOp,
  input  logic [CS_W-1:0] CCSel,
  input  logic            CCInv,
  input  logic [UA_W-1:0] BA,
  output logic [UA_W-1:0] MA,
  output logic            Done,
  output logic            Ack,
  output logic            StkErr,
  output logic [SP_W-1:0] SP
);
  localparam int IX_W = STK_DEPTH > 1 ? $clog2(STK_DEPTH) : 1;
  localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BRT = 3'd2, CALL = 3'd3,
                         RTS = 3'd4, DSP = 3'd5, MWB = 3'd6, HLT = 3'd7;
  logic [UA_W-1:0] stk [2**IX_W];
  logic [UA_W-1:0] n, nxt;
  logic [IX_W-1:0] push_ix, pop_ix;
  logic full, empty;
  assign n = MA + 1'b1;
  assign full = SP == SP_W'(STK_DEPTH);
  assign empty = SP == '0;
  assign push_ix = IX_W'(SP);
  assign pop_ix = IX_W'(SP - 1'b1);
  always_comb begin
    nxt = n;
    case (NAOp)
      JMP:  nxt = BA;
      BRT:  nxt = (CC[CCSel] ^ CCInv) ? BA : n;
      CALL: nxt = BA;
      RTS:  nxt = empty ? n : stk[pop_ix];
      DSP:  nxt = Int ? INT_VEC : {DSP_BASE, IR};
      MWB:  nxt = {BA[UA_W-1:2], CC[1:0]};
      HLT:  nxt = MA;
      default: nxt = n;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      MA <= RST_VEC;
      SP <= '0;
      Done <= 1'b0;
      Ack <= 1'b0;
      StkErr <= 1'b0;
      for (int i = 0; i < 2**IX_W; i++) stk[i] <= '0;
    end else begin
      Done <= 1'b0;
      Ack <= 1'b0;
      if (Rdy) begin
        MA <= nxt;
        if (NAOp == CALL) begin
          if (full) StkErr <= 1'b1;
          else begin
            stk[push_ix] <= n;
            SP <= SP + 1'b1;
          end
        end
        if (NAOp == RTS) begin
          if (empty) StkErr <= 1'b1;
          else SP <= SP - 1'b1;
        end
        if (NAOp == DSP) begin
          Done <= 1'b1;
          Ack <= Int;
        end
      end
    end
  end
endmodule

// File: tb/tb_minicpu_useq.sv
// tb_minicpu_useq: directed checks of the microprogram sequencer with hand-computed expectations
module tb_minicpu_useq;
  logic       Clk = 1'b0, Rst = 1'b0, Rdy = 1'b0, Int = 1'b0, CCInv = 1'b0;
  logic [3:0] CC = '0;
  logic [4:0] IR = '0;
  logic [2:0] NAOp = '0;
  logic [1:0] CCSel = '0;
  logic [7:0] BA = '0, MA;
  logic       Done, Ack, StkErr;
  logic [2:0] SP;
  int n_assert = 0, n_fail = 0;

  minicpu_useq dut (.Clk(Clk), .Rst(Rst), .Rdy(Rdy), .Int(Int), .CC(CC), .IR(IR),
    .NAOp(NAOp), .CCSel(CCSel), .CCInv(CCInv), .BA(BA), .MA(MA), .Done(Done),
    .Ack(Ack), .StkErr(StkErr), .SP(SP));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] o, input logic [7:0] b);
    NAOp = o;
    BA = b;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_ma", MA, 8'h00);
    chk("rst_sp", SP, 0);
    chk("rst_done_ack", {Done, Ack}, 0);
    chk("rst_stkerr", StkErr, 0);
    @(negedge Clk);
    Rst = 1'b1;
    Rdy = 1'b1;
    op(3'd0, 8'h00); chk("nxt1", MA, 8'h01);
    op(3'd0, 8'h00); chk("nxt2", MA, 8'h02);
    op(3'd0, 8'h00); chk("nxt3", MA, 8'h03);
    chk("nxt_done_ack", {Done, Ack}, 0);
    op(3'd1, 8'h10); chk("jmp", MA, 8'h10);
    IR = 5'h0B;
    op(3'd5, 8'h00); chk("dsp_ma", MA, 8'h2B);
    chk("dsp_done", Done, 1);
    chk("dsp_ack", Ack, 0);
    op(3'd0, 8'h00); chk("dsp_after_ma", MA, 8'h2C);
    chk("dsp_done_pulse", Done, 0);
    Int = 1'b1;
    IR = 5'h1F;
    op(3'd5, 8'h00); chk("int_ma", MA, 8'h04);
    chk("int_done_ack", {Done, Ack}, 2'b11);
    Int = 1'b0;
    op(3'd0, 8'h00); chk("int_after", {MA, Done, Ack}, {8'h05, 2'b00});
    op(3'd1, 8'h20);
    op(3'd3, 8'h40); chk("call_ma", MA, 8'h40);
    chk("call_sp", SP, 1);
    op(3'd4, 8'h00); chk("rts_ma", MA, 8'h21);
    chk("rts_sp", SP, 0);
    op(3'd3, 8'h50); op(3'd3, 8'h60); op(3'd3, 8'h70); op(3'd3, 8'h80);
    chk("call4_sp_err", {SP, StkErr}, {3'd4, 1'b0});
    op(3'd3, 8'h90); chk("call5_ma", MA, 8'h90);
    chk("call5_sp_err", {SP, StkErr}, {3'd4, 1'b1});
    op(3'd4, 8'h00); chk("pop1", {MA, SP}, {8'h71, 3'd3});
    op(3'd4, 8'h00); chk("pop2", {MA, SP}, {8'h61, 3'd2});
    op(3'd4, 8'h00); chk("pop3", {MA, SP}, {8'h51, 3'd1});
    op(3'd4, 8'h00); chk("pop4", {MA, SP}, {8'h22, 3'd0});
    op(3'd4, 8'h00); chk("underflow_ma", MA, 8'h23);
    chk("underflow_err", {SP, StkErr}, {3'd0, 1'b1});
    CCSel = 2'd2;
    CC = 4'b0100;
    op(3'd2, 8'hA0); chk("brt_taken", MA, 8'hA0);
    CCInv = 1'b1;
    op(3'd2, 8'hB0); chk("brt_inv", MA, 8'hA1);
    CCInv = 1'b0;
    Rdy = 1'b0;
    op(3'd3, 8'hC0); chk("hold_call", {MA, SP}, {8'hA1, 3'd0});
    Int = 1'b1;
    op(3'd5, 8'h00); chk("hold_dsp", {MA, Done, Ack}, {8'hA1, 2'b00});
    Int = 1'b0;
    Rdy = 1'b1;
    CC = 4'b0010;
    op(3'd6, 8'hF3); chk("mwb", MA, 8'hF2);
    op(3'd1, 8'hFF);
    op(3'd0, 8'h00); chk("wrap", MA, 8'h00);
    op(3'd1, 8'h33);
    op(3'd7, 8'h00); chk("hlt1", MA, 8'h33);
    op(3'd7, 8'h99); chk("hlt2", MA, 8'h33);
    op(3'd3, 8'h44);
    chk("pre_reset", {MA, SP, StkErr}, {8'h44, 3'd1, 1'b1});
    #2;
    Rst = 1'b0;
    #1;
    chk("async_reset", {MA, SP, StkErr, Done, Ack}, {8'h00, 3'd0, 3'b000});
    @(negedge Clk);
    Rst = 1'b1;
    op(3'd4, 8'h00); chk("stack_cleared", {MA, SP, StkErr}, {8'h01, 3'd0, 1'b1});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
